branch_feedback_tracker: RTL and testbench

Tracks every conditional branch between prediction in decode and resolution in execute. Decode pushes the branch's PC, prediction and recovery target. Execute reports only the actual outcome. The block matches the two in program order and returns registered feedback (pc, prediction, outcome) to the branch predictor. On a misprediction it produces a redirect pulse with the recovery target and squashes all younger tracked branches.

---
 rtl/mips_core_pkg.sv | 38 +++
 rtl/branch_fb_stats.sv | 47 ++++
 rtl/branch_feedback_tracker.sv | 202 ++++++++++++++++++++
 tb/tb_branch_feedback_tracker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types for branch tracking: the branch direction enum, the tracked
// branch entry and small helpers used by the feedback tracker and its counters.
// `ADDR_WIDTH supplies the default PC width; it falls back to 32 bits.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  localparam int unsigned STAT_W = 32;

  // One in-flight conditional branch as recorded at decode.
  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    BranchOutcome           prediction;
    logic [`ADDR_WIDTH-1:0] recovery_target;
  } branch_fb_entry_t;

  function automatic logic is_mispredict(input BranchOutcome predicted,
                                         input BranchOutcome actual);
    return (predicted != actual);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    if (value == {STAT_W{1'b1}}) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/branch_fb_stats.sv
// Saturating feedback statistics: counts delivered branch feedbacks and
// mispredictions. Cleared only by reset; a pipeline flush leaves them intact.
module branch_fb_stats
  import mips_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fb_valid,
  input  logic              i_mispredict,
  output logic [STAT_W-1:0] o_branches,
  output logic [STAT_W-1:0] o_mispredicts
);

  logic [STAT_W-1:0] branches_q, branches_d;
  logic [STAT_W-1:0] mispredicts_q, mispredicts_d;

  // Next-value logic for both saturating counters.
  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (i_fb_valid) begin
      branches_d = sat_inc(branches_q);
    end else begin
      branches_d = branches_q;
    end
    if (i_mispredict) begin
      mispredicts_d = sat_inc(mispredicts_q);
    end else begin
      mispredicts_d = mispredicts_q;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign o_branches    = branches_q;
  assign o_mispredicts = mispredicts_q;

endmodule

// File: rtl/branch_feedback_tracker.sv
// Branch feedback tracker: holds predicted conditional branches from decode in a
// circular queue, pairs them in order with execute outcomes, and returns
// registered feedback plus a redirect pulse on a misprediction.
// Optional statistics counters are built when BRANCH_FB_STATS_EN is defined.
// ADDR_W is expected to equal `ADDR_WIDTH, the width of the shared entry type.
module branch_feedback_tracker
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = `ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push_valid,
  input  logic [ADDR_W-1:0] i_push_pc,
  input  BranchOutcome      i_push_prediction,
  input  logic [ADDR_W-1:0] i_push_recovery_target,
  output logic              o_push_ready,
  input  logic              i_resolve_valid,
  input  BranchOutcome      i_resolve_outcome,
  input  logic              i_flush,
  output logic              o_fb_valid,
  output logic [ADDR_W-1:0] o_fb_pc,
  output BranchOutcome      o_fb_prediction,
  output BranchOutcome      o_fb_outcome,
  output logic              o_mispredict,
  output logic [ADDR_W-1:0] o_redirect_pc,
  output logic              o_err,
  output logic [31:0]       o_stat_branches,
  output logic [31:0]       o_stat_mispredicts
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  branch_fb_entry_t  mem_q [DEPTH];
  branch_fb_entry_t  mem_d [DEPTH];

  logic              fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0] fb_pc_q, fb_pc_d;
  BranchOutcome      fb_pred_q, fb_pred_d;
  BranchOutcome      fb_out_q, fb_out_d;
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              err_q, err_d;

  logic              push_ready_s;
  logic              push_acc_s;
  logic              pop_s;
  logic              mispredict_s;
  branch_fb_entry_t  head_s;

  // Ready depends only on registered state so decode sees no combinational loop.
  assign push_ready_s = (count_q != FULL_CNT) && (state_q != ST_RECOVER);

  // Queue, FSM and feedback next-state logic; flush overrides every other event.
  always_comb begin
    head_s        = mem_q[rd_ptr_q];
    push_acc_s    = i_push_valid & push_ready_s;
    pop_s         = i_resolve_valid & (count_q != '0);
    mispredict_s  = pop_s & is_mispredict(head_s.prediction, i_resolve_outcome);

    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;
    fb_valid_d    = 1'b0;
    fb_pc_d       = fb_pc_q;
    fb_pred_d     = fb_pred_q;
    fb_out_d      = fb_out_q;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    err_d         = err_q;

    if (i_flush) begin
      state_d  = ST_IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Resolving with nothing tracked or pushing while not ready is a protocol error.
      if ((i_resolve_valid && (count_q == '0)) || (i_push_valid && !push_ready_s)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end

      if (pop_s) begin
        fb_valid_d = 1'b1;
        fb_pc_d    = head_s.pc;
        fb_pred_d  = head_s.prediction;
        fb_out_d   = i_resolve_outcome;
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d   = rd_ptr_q;
      end

      if (mispredict_s) begin
        // Everything younger than the mispredicted branch is on the wrong path,
        // including a push arriving in this same cycle.
        mispredict_d  = 1'b1;
        redirect_pc_d = head_s.recovery_target;
        count_d       = '0;
        wr_ptr_d      = rd_ptr_q + PTR_ONE;
        state_d       = ST_RECOVER;
      end else begin
        if (push_acc_s) begin
          mem_d[wr_ptr_q] = '{pc: i_push_pc,
                              prediction: i_push_prediction,
                              recovery_target: i_push_recovery_target};
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end

        case ({push_acc_s, pop_s})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase

        case (state_q)
          ST_IDLE:    state_d = push_acc_s ? ST_ACTIVE : ST_IDLE;
          ST_ACTIVE:  state_d = (count_d == '0) ? ST_IDLE : ST_ACTIVE;
          ST_RECOVER: state_d = ST_IDLE;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  // State, queue storage and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      fb_valid_q    <= 1'b0;
      fb_pc_q       <= '0;
      fb_pred_q     <= NOT_TAKEN;
      fb_out_q      <= NOT_TAKEN;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
      fb_valid_q    <= fb_valid_d;
      fb_pc_q       <= fb_pc_d;
      fb_pred_q     <= fb_pred_d;
      fb_out_q      <= fb_out_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
    end
  end

  assign o_push_ready    = push_ready_s;
  assign o_fb_valid      = fb_valid_q;
  assign o_fb_pc         = fb_pc_q;
  assign o_fb_prediction = fb_pred_q;
  assign o_fb_outcome    = fb_out_q;
  assign o_mispredict    = mispredict_q;
  assign o_redirect_pc   = redirect_pc_q;
  assign o_err           = err_q;

`ifdef BRANCH_FB_STATS_EN
  branch_fb_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fb_valid   (fb_valid_q),
    .i_mispredict (mispredict_q),
    .o_branches   (o_stat_branches),
    .o_mispredicts(o_stat_mispredicts)
  );
`else
  assign o_stat_branches    = 32'd0;
  assign o_stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_feedback_tracker.sv
// Directed bench for branch_feedback_tracker: stimulus pushes hand-computed
// expected feedback into a scoreboard queue; a negedge monitor pops and compares
// every feedback pulse. Statistics expectations follow BRANCH_FB_STATS_EN.
module tb_branch_feedback_tracker;
  import mips_core_pkg::*;

  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] pc;
    BranchOutcome  pred;
    BranchOutcome  outc;
    logic          mis;
    logic [AW-1:0] redir;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_push_valid = 1'b0;
  logic [AW-1:0] i_push_pc = '0;
  BranchOutcome  i_push_prediction = NOT_TAKEN;
  logic [AW-1:0] i_push_recovery_target = '0;
  logic          o_push_ready;
  logic          i_resolve_valid = 1'b0;
  BranchOutcome  i_resolve_outcome = NOT_TAKEN;
  logic          i_flush = 1'b0;
  logic          o_fb_valid;
  logic [AW-1:0] o_fb_pc;
  BranchOutcome  o_fb_prediction;
  BranchOutcome  o_fb_outcome;
  logic          o_mispredict;
  logic [AW-1:0] o_redirect_pc;
  logic          o_err;
  logic [31:0]   o_stat_branches;
  logic [31:0]   o_stat_mispredicts;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  branch_feedback_tracker #(.DEPTH(4), .ADDR_W(AW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_push_valid          (i_push_valid),
    .i_push_pc             (i_push_pc),
    .i_push_prediction     (i_push_prediction),
    .i_push_recovery_target(i_push_recovery_target),
    .o_push_ready          (o_push_ready),
    .i_resolve_valid       (i_resolve_valid),
    .i_resolve_outcome     (i_resolve_outcome),
    .i_flush               (i_flush),
    .o_fb_valid            (o_fb_valid),
    .o_fb_pc               (o_fb_pc),
    .o_fb_prediction       (o_fb_prediction),
    .o_fb_outcome          (o_fb_outcome),
    .o_mispredict          (o_mispredict),
    .o_redirect_pc         (o_redirect_pc),
    .o_err                 (o_err),
    .o_stat_branches       (o_stat_branches),
    .o_stat_mispredicts    (o_stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every feedback pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_fb_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_fb: got pc %0h with no feedback expected", o_fb_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (o_fb_pc !== e.pc || o_fb_prediction !== e.pred || o_fb_outcome !== e.outc ||
              o_mispredict !== e.mis || (e.mis && o_redirect_pc !== e.redir)) begin
            miscompares++;
            $display("FAIL feedback: got pc=%0h pred=%0d out=%0d mis=%0d redir=%0h, expected pc=%0h pred=%0d out=%0d mis=%0d redir=%0h",
                     o_fb_pc, o_fb_prediction, o_fb_outcome, o_mispredict, o_redirect_pc,
                     e.pc, e.pred, e.outc, e.mis, e.redir);
          end
        end
      end else if (o_mispredict) begin
        vectors++;
        miscompares++;
        $display("FAIL mispredict_alone: got o_mispredict=1, expected 0 without o_fb_valid");
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that sampled it.
  task automatic step(input logic pv, input logic [AW-1:0] pc, input BranchOutcome pred,
                      input logic [AW-1:0] tgt, input logic rv, input BranchOutcome ro,
                      input logic fl);
    i_push_valid           = pv;
    i_push_pc              = pc;
    i_push_prediction      = pred;
    i_push_recovery_target = tgt;
    i_resolve_valid        = rv;
    i_resolve_outcome      = ro;
    i_flush                = fl;
    @(posedge clk);
    #1;
    i_push_valid    = 1'b0;
    i_resolve_valid = 1'b0;
    i_flush         = 1'b0;
  endtask

  task automatic push_br(input logic [AW-1:0] pc, input BranchOutcome pred, input logic [AW-1:0] tgt);
    step(1'b1, pc, pred, tgt, 1'b0, NOT_TAKEN, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, NOT_TAKEN, '0, 1'b0, NOT_TAKEN, 1'b0);
  endtask

  task automatic expect_fb(input logic [AW-1:0] pc, input BranchOutcome pred,
                           input BranchOutcome outc, input logic mis, input logic [AW-1:0] redir);
    exp_t e;
    e.pc = pc; e.pred = pred; e.outc = outc; e.mis = mis; e.redir = redir;
    sb.push_back(e);
  endtask

  // Resolve the oldest branch, expecting the given feedback.
  task automatic resolve_br(input BranchOutcome ro, input logic [AW-1:0] pc, input BranchOutcome pred,
                            input logic mis, input logic [AW-1:0] redir);
    expect_fb(pc, pred, ro, mis, redir);
    step(1'b0, '0, NOT_TAKEN, '0, 1'b1, ro, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Reset values
    check("rst_push_ready", {31'd0, o_push_ready}, 32'd1);
    check("rst_fb_valid", {31'd0, o_fb_valid}, 32'd0);
    check("rst_mispredict", {31'd0, o_mispredict}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_fb_pc", o_fb_pc, 32'd0);
    check("rst_redirect_pc", o_redirect_pc, 32'd0);
    check("rst_fb_pred", {31'd0, o_fb_prediction}, 32'd0);
    check("rst_stat_branches", o_stat_branches, 32'd0);

    // Correct TAKEN prediction
    push_br(32'h100, TAKEN, 32'h108);
    resolve_br(TAKEN, 32'h100, TAKEN, 1'b0, 32'h0);
    idle();

    // Misprediction squashes the younger branch, one recovery cycle
    push_br(32'h200, NOT_TAKEN, 32'h240);
    push_br(32'h210, TAKEN, 32'h218);
    resolve_br(TAKEN, 32'h200, NOT_TAKEN, 1'b1, 32'h240);
    check("recover_ready_low", {31'd0, o_push_ready}, 32'd0);
    idle();
    check("recover_ready_high", {31'd0, o_push_ready}, 32'd1);
    check("err_before_empty_resolve", {31'd0, o_err}, 32'd0);
    step(1'b0, '0, NOT_TAKEN, '0, 1'b1, TAKEN, 1'b0);
    check("err_empty_resolve", {31'd0, o_err}, 32'd1);
    idle();

    // Fill, overflow push, drain in order
    do_reset();
    check("err_cleared_by_reset", {31'd0, o_err}, 32'd0);
    push_br(32'h300, NOT_TAKEN, 32'h380);
    push_br(32'h304, NOT_TAKEN, 32'h384);
    push_br(32'h308, NOT_TAKEN, 32'h388);
    check("ready_three_entries", {31'd0, o_push_ready}, 32'd1);
    push_br(32'h30C, NOT_TAKEN, 32'h38C);
    check("full_ready_low", {31'd0, o_push_ready}, 32'd0);
    check("full_err_still_low", {31'd0, o_err}, 32'd0);
    push_br(32'h310, NOT_TAKEN, 32'h390);
    check("overflow_err", {31'd0, o_err}, 32'd1);
    resolve_br(NOT_TAKEN, 32'h300, NOT_TAKEN, 1'b0, 32'h0);
    resolve_br(NOT_TAKEN, 32'h304, NOT_TAKEN, 1'b0, 32'h0);
    resolve_br(NOT_TAKEN, 32'h308, NOT_TAKEN, 1'b0, 32'h0);
    resolve_br(NOT_TAKEN, 32'h30C, NOT_TAKEN, 1'b0, 32'h0);
    idle();

    // Full queue: push with resolve is dropped; with room, push+resolve keeps count
    push_br(32'h400, TAKEN, 32'h480);
    push_br(32'h404, TAKEN, 32'h484);
    push_br(32'h408, TAKEN, 32'h488);
    push_br(32'h40C, TAKEN, 32'h48C);
    expect_fb(32'h400, TAKEN, TAKEN, 1'b0, 32'h0);
    step(1'b1, 32'h410, TAKEN, 32'h490, 1'b1, TAKEN, 1'b0);
    check("ready_after_full_pop", {31'd0, o_push_ready}, 32'd1);
    expect_fb(32'h404, TAKEN, TAKEN, 1'b0, 32'h0);
    step(1'b1, 32'h414, TAKEN, 32'h494, 1'b1, TAKEN, 1'b0);
    check("ready_push_pop_same", {31'd0, o_push_ready}, 32'd1);
    push_br(32'h418, TAKEN, 32'h498);
    check("refull_ready_low", {31'd0, o_push_ready}, 32'd0);
    resolve_br(TAKEN, 32'h408, TAKEN, 1'b0, 32'h0);
    resolve_br(TAKEN, 32'h40C, TAKEN, 1'b0, 32'h0);
    resolve_br(TAKEN, 32'h414, TAKEN, 1'b0, 32'h0);
    resolve_br(TAKEN, 32'h418, TAKEN, 1'b0, 32'h0);
    idle();

    // Flush with three entries and a simultaneous resolve
    do_reset();
    push_br(32'h500, TAKEN, 32'h580);
    push_br(32'h504, TAKEN, 32'h584);
    push_br(32'h508, TAKEN, 32'h588);
    step(1'b0, '0, NOT_TAKEN, '0, 1'b1, TAKEN, 1'b1);
    check("flush_ready", {31'd0, o_push_ready}, 32'd1);
    push_br(32'h600, TAKEN, 32'h680);
    resolve_br(TAKEN, 32'h600, TAKEN, 1'b0, 32'h0);
    idle();

    // Reset mid-operation drops the entry with no feedback
    push_br(32'h700, TAKEN, 32'h780);
    do_reset();
    idle();
    check("midreset_ready", {31'd0, o_push_ready}, 32'd1);

    // Statistics: five resolves, two mispredicted; push during mispredict is discarded
    push_br(32'h800, TAKEN, 32'h880);
    resolve_br(TAKEN, 32'h800, TAKEN, 1'b0, 32'h0);
    push_br(32'h810, NOT_TAKEN, 32'h890);
    resolve_br(TAKEN, 32'h810, NOT_TAKEN, 1'b1, 32'h890);
    idle();
    push_br(32'h820, TAKEN, 32'h8A0);
    push_br(32'h830, TAKEN, 32'h8B0);
    resolve_br(TAKEN, 32'h820, TAKEN, 1'b0, 32'h0);
    expect_fb(32'h830, TAKEN, NOT_TAKEN, 1'b1, 32'h8B0);
    step(1'b1, 32'h840, TAKEN, 32'h8C0, 1'b1, NOT_TAKEN, 1'b0);
    check("recover2_ready_low", {31'd0, o_push_ready}, 32'd0);
    idle();
    push_br(32'h850, NOT_TAKEN, 32'h8D0);
    resolve_br(NOT_TAKEN, 32'h850, NOT_TAKEN, 1'b0, 32'h0);
    idle();
    idle();
    check("stats_err_clear", {31'd0, o_err}, 32'd0);
`ifdef BRANCH_FB_STATS_EN
    check("stat_branches", o_stat_branches, 32'd5);
    check("stat_mispredicts", o_stat_mispredicts, 32'd2);
`else
    check("stat_branches", o_stat_branches, 32'd0);
    check("stat_mispredicts", o_stat_mispredicts, 32'd0);
`endif

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
